// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains the read side of the asynchronous FIFO.
// Each popped word goes out as start, LSB-first data, optional parity and stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [CNT_WIDTH-1:0]  bit_period,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cyc_cnt;
  logic [CNT_WIDTH-1:0]  p_last;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_WIDTH-1:0]  p_last_next;
  logic                  par_en_reg;
  logic                  par_bit_reg;
  logic                  cyc_done;
  logic                  last_bit;
  logic                  load;

  assign cyc_done    = (cyc_cnt == p_last);
  assign last_bit    = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign shift_next  = shift_reg >> 1;
  // A period of 0 behaves as 1; storing P-1 keeps the counter compare simple.
  assign p_last_next = (bit_period == '0) ? '0 : bit_period - CNT_WIDTH'(1);

  // Rempty is only looked at here, so the cycle after a pop never sees a stale flag.
  assign load = !rempty && ((state == IDLE) || ((state == STOP) && cyc_done));
  assign rinc = load && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      p_last      <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else if (load) begin
      state       <= START;
      tx_out      <= 1'b0;
      busy        <= 1'b1;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= rdata;
      p_last      <= p_last_next;
      par_en_reg  <= par_en;
      par_bit_reg <= (^rdata) ^ par_typ;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        START: begin
          if (cyc_done) begin
            state   <= DATA;
            cyc_cnt <= '0;
            tx_out  <= shift_reg[0];
          end else begin
            cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
          end
        end
        DATA: begin
          if (cyc_done) begin
            cyc_cnt <= '0;
            if (last_bit) begin
              bit_cnt <= '0;
              if (par_en_reg) begin
                state  <= PARITY;
                tx_out <= par_bit_reg;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + BIT_W'(1);
              shift_reg <= shift_next;
              tx_out    <= shift_next[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
          end
        end
        PARITY: begin
          if (cyc_done) begin
            state   <= STOP;
            cyc_cnt <= '0;
            tx_out  <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
          end
        end
        STOP: begin
          // Reaching here at the end of the stop bit means no byte was waiting.
          if (cyc_done) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tx_out  <= 1'b1;
          busy    <= 1'b0;
          cyc_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer of the asynchronous FIFO in the multi-clock system. It runs in the FIFO read (UART TX) clock domain. Whenever the FIFO is non-empty, it pops one byte with a single-cycle `rinc` pulse and serializes that byte on `tx_out` as a UART frame: start bit, data LSB-first, optional parity bit, stop bit. Bit period and parity are run-time configurable from the register file. It is the last stage before the chip's serial output.

## Interface
- `DATA_WIDTH`, default 8: width of FIFO words and of the UART data field.
- `CNT_WIDTH`, default 8: width of the bit-period configuration and of the internal cycle counter.

- `clk`  in  1: read-domain clock, the same clock that drives FIFO `rclk`.
- `rst`  in  1: synchronous, active-high reset.
- `rempty`  in  1: FIFO empty flag, read domain.
- `rdata`  in  DATA_WIDTH: FIFO head word. Valid whenever `rempty`=0.
- `rinc`  out  1: FIFO pop strobe, one cycle per byte.
- `par_en`  in  1: parity bit enable.
- `par_typ`  in  1: parity type, 0 = even, 1 = odd.
- `bit_period`  in  CNT_WIDTH: clock cycles per UART bit. The value 0 is treated as 1.
- `tx_out`  out  1: serial line. Idles high.
- `busy`  out  1: high while a frame is on the line.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- Load condition: (state==IDLE, or the last cycle of STOP) and `rempty`==0.
- On load, in that same cycle:
  - `rinc`=1, combinational from state, counters and `rempty`.
  - `rdata` is captured into the shift register.
  - `par_en`, `par_typ` and the effective bit period are latched.
  - Parity is computed from the captured byte: XOR of the bits, inverted when `par_typ`=1.
- Configuration inputs are ignored mid-frame. Only the values latched at load apply.
- Frame sequence:
  - START: `tx_out`=0.
  - DATA: DATA_WIDTH bits, LSB first.
  - PARITY: only if latched `par_en`=1.
  - STOP: `tx_out`=1.
  - Each state lasts exactly P cycles, where P is the latched effective bit period.
- Transitions:
  - IDLE→START on load.
  - START→DATA after P cycles.
  - DATA→PARITY or STOP after DATA_WIDTH×P cycles.
  - PARITY→STOP after P cycles.
  - STOP→START if the load condition holds in its last cycle; otherwise STOP→IDLE.
- Back-to-back frames have no idle bit between them.
- `tx_out` and `busy` are registered outputs.
  - `busy`=1 in START, DATA, PARITY and STOP; `busy`=0 in IDLE.
  - `tx_out`=1 in IDLE.
- `rempty` is sampled only at load points. It is never sampled during the cycle after `rinc`, which covers the registered empty-flag update latency.
- Reset values: state=IDLE, `tx_out`=1, `busy`=0, `rinc`=0, all counters 0.
- Reset mid-frame:
  - From the next cycle, `tx_out`=1 and `busy`=0.
  - The popped byte is discarded and is not re-read.
  - `rinc` is forced to 0 while `rst`=1.
- If `rempty`=1 at every load point, the block stays in IDLE indefinitely with no `rinc`.

## Timing
- Latency: `tx_out` falls in the cycle after the `rinc` pulse.
- Frame length: (DATA_WIDTH+2+par_en)×P cycles. For the defaults this is 10P without parity and 11P with parity.
- Pop spacing: consecutive `rinc` pulses are exactly one frame length apart when the FIFO stays non-empty.
- `rinc` is never high on two consecutive cycles. The minimum frame length is 10 cycles.
- Bit counter: 0..DATA_WIDTH-1. Cycle counter: 0..P-1.
- No counter overflows for P ≤ 2^CNT_WIDTH−1.

## Test plan
- Plain frame: FIFO holds 0xA5, `bit_period`=4, `par_en`=0.
  - One `rinc` pulse.
  - `tx_out` reads 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles, for 40 cycles total.
  - `busy` is high for exactly 40 cycles, then the line returns to IDLE.
- Parity: 0xA5 with `par_en`=1.
  - `par_typ`=0 gives parity bit 0.
  - `par_typ`=1 gives parity bit 1.
  - Frame is 44 cycles at P=4.
  - 0x01 with even parity gives parity bit 1.
- Back-to-back: FIFO holds 0x3C then 0xC3, P=2.
  - Two `rinc` pulses, exactly 20 cycles apart.
  - The second start bit immediately follows the first stop bit.
  - `busy` stays high for 40 cycles.
- Degenerate period and config change:
  - `bit_period`=0 gives 1-cycle bits and a 10-cycle frame.
  - Changing `bit_period` from 4 to 8 mid-frame leaves the current frame at P=4.
  - The next frame uses P=8.
- Empty FIFO: `rempty` held 1 for 100 cycles.
  - `rinc`=0 throughout.
  - `tx_out`=1 and `busy`=0 throughout.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0xA5.
  - The next cycle shows `tx_out`=1 and `busy`=0.
  - After `rst` deasserts with the FIFO holding 0x5A, the next frame carries 0x5A, not 0xA5.
